// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and address-check helpers for the memory responder
package mem_responder_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mresp_state_t;

  typedef struct packed {
    logic [31:0]           adr;
    logic                  we;
    logic [31:0]           wd;
    logic [WORD_BYTES-1:0] be;
  } mresp_req_t;

  // Any byte-address bit above the word-index field marks the access as out of range.
  function automatic logic out_of_range(input logic [31:0] adr, input int unsigned aw);
    return (adr >> (aw + 2)) != 32'd0;
  endfunction

  function automatic logic misaligned(input logic [31:0] adr);
    return adr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - word array with byte-enable synchronous write and combinational read
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [31:0]           wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [31:0]           rd
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem_q[wa][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated single-word memory responder (FSM, range check, response registers)
// Optional feature: MEM_RESPONDER_ALIGN_CHECK_EN rejects accesses with adr[1:0] != 0.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  mresp_state_t          state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  mresp_req_t            req_q, req_d;
  logic [31:0]           rd_q, rd_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic                  bad;
  logic                  arr_we;
  logic [31:0]           arr_rd;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign word_idx = req_q.adr[ADDR_WIDTH+1:2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign bad = out_of_range(req_q.adr, ADDR_WIDTH) | misaligned(req_q.adr);
`else
  logic unused_align;
  assign unused_align = |req_q.adr[1:0];
  assign bad          = out_of_range(req_q.adr, ADDR_WIDTH);
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    req_d   = req_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    arr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          req_d   = '{adr: adr, we: we, wd: wd, be: be};
          count_d = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ready_d = 1'b1;
        err_d   = bad;
        state_d = IDLE;
        if (bad) begin
          rd_d = '0;
        end else if (!req_q.we) begin
          rd_d = arr_rd;
        end
        // A reset landing on the commit edge must drop the pending write.
        arr_we = req_q.we && !bad && !reset;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // The latched request is data only; state alone decides whether it is used.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  mem_responder_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk(clk),
    .we (arr_we),
    .be (req_q.be),
    .wa (word_idx),
    .wd (req_q.wd),
    .ra (word_idx),
    .rd (arr_rd)
  );

  assign rd    = rd_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed and randomized checks of mem_responder against a word-array model
module tb_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, we;
  logic [31:0] adr, wd, rd;
  logic [3:0]  be;
  logic        ready, err;

  logic        reset0, req0, we0;
  logic [31:0] adr0, wd0, rd0;
  logic [3:0]  be0;
  logic        ready0, err0;

  int errors = 0;
  int checks = 0;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic [31:0] model [0:15];
  logic [31:0] last_rd;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr), .wd(wd), .be(be),
    .rd(rd), .ready(ready), .err(err)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .adr(adr0), .wd(wd0), .be(be0),
    .rd(rd0), .ready(ready0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] r, output logic e, output int lat, output logic wide1);
    @(negedge clk);
    req = 1'b1; we = w; adr = a; wd = d; be = b;
    @(negedge clk);
    req = 1'b0; we = ~w; adr = $urandom; wd = $urandom; be = 4'($urandom);
    lat = 0;
    while (!ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = rd;
    e = err;
    @(negedge clk);
    wide1 = !ready;
  endtask

  task automatic op(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    logic [31:0] r;
    logic        e;
    int          lat;
    logic        w1;
    logic        bad;
    logic [31:0] exp_rd;
    int          idx;
    bad = ((a >> 10) != 32'd0) || (ALIGN && (a[1:0] != 2'b00));
    idx = int'(a[5:2]);
    if (bad) begin
      exp_rd = 32'd0;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      exp_rd = last_rd;
    end else begin
      exp_rd = model[idx];
    end
    xact(w, a, d, b, r, e, lat, w1);
    last_rd = exp_rd;
    chk({tag, ".latency"}, 32'(lat), 32'd3);
    chk({tag, ".err"}, 32'(e), 32'(bad));
    chk({tag, ".rd"}, r, exp_rd);
    chk({tag, ".ready_1wide"}, 32'(w1), 32'd1);
  endtask

  initial begin
    int          n;
    int          pulses;
    logic [31:0] a;

    reset = 1'b1; req = 1'b0; we = 1'b0; adr = '0; wd = '0; be = '0;
    reset0 = 1'b1; req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0; be0 = '0;
    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(ready), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.rd", rd, 32'd0);
    chk("reset.ready0", 32'(ready0), 32'd0);
    reset = 1'b0;
    reset0 = 1'b0;
    last_rd = 32'd0;

    for (int i = 0; i < 16; i++) op("init", 1'b1, 32'(i * 4), $urandom, 4'hF);

    op("t1.wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    op("t1.rd", 1'b0, 32'h10, 32'h0, 4'h0);
    chk("t1.rd_value", rd, 32'hDEADBEEF);

    op("t2.wr", 1'b1, 32'h10, 32'h00000055, 4'b0001);
    op("t2.rd", 1'b0, 32'h10, 32'h0, 4'hF);
    chk("t2.rd_value", rd, 32'hDEADBE55);

    op("t2.be0_wr", 1'b1, 32'h14, $urandom, 4'b0000);
    op("t2.be0_rd", 1'b0, 32'h14, 32'h0, 4'h0);

    op("t3.oor_rd", 1'b0, 32'h400, 32'h0, 4'h0);
    op("t3.oor_wr", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
    op("t3.word0", 1'b0, 32'h0, 32'h0, 4'h0);

    op("t4.pre", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h20; wd = 32'h12345678; be = 4'hF;
    @(negedge clk);
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4.rd_after_reset", rd, 32'd0);
    last_rd = 32'd0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready) pulses++;
      @(negedge clk);
    end
    chk("t4.no_ready_wait_abort", 32'(pulses), 32'd0);
    op("t4.rd", 1'b0, 32'h20, 32'h0, 4'h0);
    chk("t4.old_value", rd, 32'hCAFEF00D);

    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h20; wd = 32'hAAAA5555; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4.no_ready_resp_abort", 32'(ready), 32'd0);
    last_rd = 32'd0;
    op("t4.rd_resp_abort", 1'b0, 32'h20, 32'h0, 4'h0);

    @(negedge clk);
    reset = 1'b1; req = 1'b1; we = 1'b1; adr = 32'h20; wd = 32'h11111111; be = 4'hF;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready) pulses++;
      @(negedge clk);
    end
    chk("t4.reset_beats_req", 32'(pulses), 32'd0);
    last_rd = 32'd0;
    op("t4.rd_after_req_reset", 1'b0, 32'h20, 32'h0, 4'h0);

    op("t6.align", 1'b0, 32'h13, 32'h0, 4'h0);
    chk("t6.err", 32'(err), 32'(ALIGN));

    for (int k = 0; k < 150; k++) begin
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
      op("rnd", 1'($urandom), a, $urandom, 4'($urandom));
    end

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h8; wd0 = 32'h0BADF00D; be0 = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready0 && n < 10);
    chk("t5.first_latency", 32'(n), 32'd2);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t5.pulse_pattern", 32'(ready0), 32'((k % 2) == 0));
    end
    we0 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready0 && n < 10);
    chk("t5.read_latency", 32'(n), 32'd2);
    chk("t5.read_rd", rd0, 32'h0BADF00D);
    chk("t5.read_err", 32'(err0), 32'd0);
    @(negedge clk);
    chk("t5.read_1wide", 32'(ready0), 32'd0);
    req0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
